ring_johnson_counter: RTL and testbench

- Parametrised successor of the team's fixed 4-bit ring counter.
- Provides a WIDTH-bit circular shift counter that runs in ring (one-hot) or Johnson (twisted-ring) mode, in either direction.
- Adds count enable, parallel load, a wrap pulse and self-correction of illegal states.
- Used as a sequencer/phase generator for one-hot strobes and timing slots.

---
 rtl/ring_counter_pkg.sv | 20 ++
 rtl/ring_state_check.sv | 30 +++
 rtl/ring_johnson_counter.sv | 90 +++++++++
 tb/tb_ring_johnson_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and seed helper for the ring/Johnson sequencer family.
// Seeds are returned at a fixed maximum width; callers truncate to their WIDTH.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    localparam int unsigned MAX_WIDTH = 64;

    // Ring seed is one-hot bit 0, Johnson seed is all zeros.
    function automatic logic [MAX_WIDTH-1:0] seed(input logic mode, input int unsigned width);
        seed = '0;
        if (mode == MODE_RING && width != 0) begin
            seed[0] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check for ring (one-hot) and Johnson (anchored run) states.
// Reusable by any sequencer that needs to recognise its legal state set.
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             legal
);

    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_inv;
    logic [WIDTH-1:0] q_inv_inc;
    logic             ring_ok;
    logic             johnson_ok;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        q_inc      = q + WIDTH'(1);
        q_inv      = ~q;
        q_inv_inc  = q_inv + WIDTH'(1);
        // Sums are held in WIDTH-bit variables so the carry out of the top bit is dropped.
        ring_ok    = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
        johnson_ok = ((q & q_inc) == '0) || ((q_inv & q_inv_inc) == '0);
        legal      = (mode == MODE_JOHNSON) ? johnson_ok : ring_ok;
    end

endmodule

// File: rtl/ring_johnson_counter.sv
// WIDTH-bit ring / Johnson shift counter with load, direction, wrap pulse
// and self-correction of illegal states while stepping.
module ring_johnson_counter
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] stepped;
    logic             fb_left;
    logic             fb_right;
    logic             legal;

    ring_state_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .q     (cnt_q),
        .mode  (mode_q),
        .legal (legal)
    );

    always_comb begin
        seed_in   = WIDTH'(seed(mode, WIDTH));
        seed_cur  = WIDTH'(seed(mode_q, WIDTH));
        // Johnson feeds back the inverted outgoing bit, ring feeds it back unchanged.
        fb_left   = (mode_q == MODE_JOHNSON) ? ~cnt_q[WIDTH-1] : cnt_q[WIDTH-1];
        fb_right  = (mode_q == MODE_JOHNSON) ? ~cnt_q[0]       : cnt_q[0];
        stepped   = (dir == DIR_LEFT) ? {cnt_q[WIDTH-2:0], fb_left}
                                      : {fb_right, cnt_q[WIDTH-1:1]};

        cnt_d     = cnt_q;
        mode_d    = mode_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;

        if (load) begin
            cnt_d  = load_val;
            mode_d = mode;
        end else if (mode != mode_q) begin
            cnt_d  = seed_in;
            mode_d = mode;
        end else if (en) begin
            if (!legal) begin
                cnt_d     = seed_cur;
                illegal_d = 1'b1;
            end else begin
                cnt_d  = stepped;
                wrap_d = (stepped == seed_cur);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= WIDTH'(seed(mode, WIDTH));
            mode_q    <= mode;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end

    assign q       = cnt_q;
    assign wrap    = wrap_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Bench for ring_johnson_counter: directed sequences with literal expectations,
// then random stimulus checked every cycle against a state-table model.
module tb_ring_johnson_counter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         dir;
    logic         mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         wrap;
    logic         illegal;

    int n_checks = 0;
    int n_pass   = 0;

    ring_johnson_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the legal states of each mode listed in stepping order (left = index+1).
    function automatic int period(input logic m);
        return m ? 2 * W : W;
    endfunction

    function automatic logic [W-1:0] state_at(input logic m, input int k);
        int v;
        if (!m) v = 1 << k;
        else if (k <= W) v = (1 << k) - 1;
        else v = ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
        return v[W-1:0];
    endfunction

    function automatic int index_of(input logic m, input logic [W-1:0] v);
        for (int k = 0; k < period(m); k++) begin
            if (state_at(m, k) == v) return k;
        end
        return -1;
    endfunction

    logic [W-1:0] m_q;
    logic         m_mode;
    logic         m_wrap;
    logic         m_ill;
    bit           model_valid = 1'b0;

    always @(posedge clk) begin
        int idx;
        int nxt;
        m_wrap = 1'b0;
        m_ill  = 1'b0;
        if (rst) begin
            m_mode      = mode;
            m_q         = state_at(mode, 0);
            model_valid = 1'b1;
        end else if (load) begin
            m_mode = mode;
            m_q    = load_val;
        end else if (mode != m_mode) begin
            m_mode = mode;
            m_q    = state_at(mode, 0);
        end else if (en) begin
            idx = index_of(m_mode, m_q);
            if (idx < 0) begin
                m_q   = state_at(m_mode, 0);
                m_ill = 1'b1;
            end else begin
                nxt    = dir ? (idx + period(m_mode) - 1) % period(m_mode)
                             : (idx + 1) % period(m_mode);
                m_q    = state_at(m_mode, nxt);
                m_wrap = (nxt == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_q", q, m_q);
            check("model_wrap", wrap, m_wrap);
            check("model_illegal", illegal, m_ill);
        end
    end

    task automatic expect_step(input string name, input logic [W-1:0] eq,
                               input logic ew, input logic ei);
        @(posedge clk);
        @(negedge clk);
        check({name, "_q"}, q, eq);
        check({name, "_wrap"}, wrap, ew);
        check({name, "_illegal"}, illegal, ei);
    endtask

    initial begin
        logic [W-1:0] jseq [8];
        jseq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        expect_step("reset_ring", 4'b0001, 1'b0, 1'b0);

        rst = 1'b0; en = 1'b1; dir = 1'b0;
        expect_step("ring_l1", 4'b0010, 1'b0, 1'b0);
        expect_step("ring_l2", 4'b0100, 1'b0, 1'b0);
        expect_step("ring_l3", 4'b1000, 1'b0, 1'b0);
        expect_step("ring_l4", 4'b0001, 1'b1, 1'b0);
        expect_step("ring_l5", 4'b0010, 1'b0, 1'b0);

        rst = 1'b1; mode = 1'b1; en = 1'b0;
        expect_step("reset_john", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_step("john_l", jseq[i], (i == 7), 1'b0);
        end

        rst = 1'b1; mode = 1'b0; en = 1'b0;
        expect_step("reset_ring2", 4'b0001, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b1; dir = 1'b1;
        expect_step("ring_r1", 4'b1000, 1'b0, 1'b0);
        expect_step("ring_r2", 4'b0100, 1'b0, 1'b0);
        expect_step("ring_r3", 4'b0010, 1'b0, 1'b0);
        expect_step("ring_r4", 4'b0001, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) expect_step("ring_hold", 4'b0001, 1'b0, 1'b0);

        dir = 1'b0; load = 1'b1; load_val = 4'b0101;
        expect_step("load_ring", 4'b0101, 1'b0, 1'b0);
        load = 1'b0;
        expect_step("ill_hold1", 4'b0101, 1'b0, 1'b0);
        expect_step("ill_hold2", 4'b0101, 1'b0, 1'b0);
        en = 1'b1;
        expect_step("ill_ring", 4'b0001, 1'b0, 1'b1);
        expect_step("ill_ring_after", 4'b0010, 1'b0, 1'b0);

        en = 1'b0; mode = 1'b1; load = 1'b1; load_val = 4'b0110;
        expect_step("load_john", 4'b0110, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        expect_step("ill_john", 4'b0000, 1'b0, 1'b1);

        rst = 1'b1; mode = 1'b0; en = 1'b0;
        expect_step("reset_ring3", 4'b0001, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b1;
        expect_step("sw_a", 4'b0010, 1'b0, 1'b0);
        expect_step("sw_b", 4'b0100, 1'b0, 1'b0);
        mode = 1'b1;
        expect_step("sw_reseed", 4'b0000, 1'b0, 1'b0);
        expect_step("sw_next", 4'b0001, 1'b0, 1'b0);

        rst = 1'b1; load = 1'b1; load_val = 4'b1010; mode = 1'b0; en = 1'b0;
        expect_step("prio_rst_load", 4'b0001, 1'b0, 1'b0);
        rst = 1'b0; load_val = 4'b0110; mode = 1'b1;
        expect_step("prio_load_mode", 4'b0110, 1'b0, 1'b0);
        load = 1'b0;
        expect_step("prio_no_reseed", 4'b0110, 1'b0, 1'b0);
        en = 1'b1;
        expect_step("prio_john_fix", 4'b0000, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(99) < 2);
            load     = ($urandom_range(99) < 5);
            load_val = W'($urandom);
            if ($urandom_range(99) < 4) mode = ~mode;
            en       = ($urandom_range(99) < 75);
            dir      = ($urandom_range(99) < 30) ? ~dir : dir;
            @(negedge clk);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
